wam_game_core: RTL

WAM_GAME_CORE -- requirements
Module: wam_game_core

---
 rtl/wam_game_core.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wam_game_core.sv
// Whack-a-mole game controller: sequences countdown, play and game-over,
// and keeps score, flick count, remaining time and remaining lives for the
// three game modes (points, timed, lives). Light and key events come from
// peer blocks; o_clear_n resets those peers for the single RESTART cycle.
//
// Event handshake: every event input (i_play, i_tick_1hz, i_light_new,
// i_light_expired, i_key_valid) is a one-cycle strobe that is consumed on
// the rising edge where it is high; there is no back-pressure.
module wam_game_core #(
    parameter int NUM_LIGHTS    = 9,
    parameter int SCORE_W       = 7,
    parameter int READY_SECONDS = 5,
    parameter int GAME_SECONDS  = 60,
    parameter int LIVES         = 3,
    localparam int POS_W        = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_play,
    input  logic [1:0]         i_mode,
    input  logic [SCORE_W-1:0] i_max_hits,
    input  logic               i_tick_1hz,
    input  logic               i_light_new,
    input  logic               i_light_valid,
    input  logic [POS_W-1:0]   i_light_pos,
    input  logic               i_light_expired,
    input  logic               i_key_valid,
    input  logic [POS_W-1:0]   i_key_pos,
    output logic [2:0]         o_state,
    output logic               o_clear_n,
    output logic               o_countdown_en,
    output logic               o_flick_en,
    output logic               o_game_over,
    output logic [3:0]         o_ready_count,
    output logic [6:0]         o_time_left,
    output logic [2:0]         o_lives_left,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_flicks
);

    // Game phases; the encoding is visible on o_state for observers.
    typedef enum logic [2:0] {
        ST_SETUP     = 3'd0,
        ST_WAIT      = 3'd1,
        ST_PLAY      = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_RESTART   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_TIMED = 2'd1;
    localparam logic [1:0] MODE_LIVES = 2'd2;

    state_t             r_state;
    state_t             w_state_next;

    // Game configuration, captured only when leaving RESTART so that
    // changes on i_mode / i_max_hits mid-game do not disturb the game.
    logic [1:0]         r_mode_q;
    logic [SCORE_W-1:0] r_max_q;

    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_flicks;
    logic [3:0]         r_ready_count;
    logic [6:0]         r_time_left;
    logic [2:0]         r_lives_left;
    // Set once the current light has been hit; further presses on it are misses.
    logic               r_hit_lock;

    logic [1:0]         w_mode_next;
    logic [SCORE_W-1:0] w_max_next;
    logic [SCORE_W-1:0] w_score_next;
    logic [SCORE_W-1:0] w_flicks_next;
    logic [3:0]         w_ready_next;
    logic [6:0]         w_time_next;
    logic [2:0]         w_lives_next;
    logic               w_hit_lock_next;

    // Per-cycle play evaluation
    logic               w_mode_timed;
    logic               w_mode_lives;
    logic               w_lock_eff;
    logic               w_hit;
    logic               w_key_miss;
    logic               w_exp_miss;
    logic [1:0]         w_miss_cnt;
    logic [SCORE_W-1:0] w_score_play;
    logic [SCORE_W-1:0] w_flicks_play;
    logic [6:0]         w_time_play;
    logic [2:0]         w_lives_play;
    logic               w_play_end;

    // Hit/miss judgement and the counter values PLAY would produce this cycle.
    always_comb begin
        w_mode_timed = (r_mode_q == MODE_TIMED);
        w_mode_lives = (r_mode_q == MODE_LIVES);

        // A new light in this cycle means the key is judged against a fresh,
        // never-hit light.
        w_lock_eff = i_light_new ? 1'b0 : r_hit_lock;

        w_hit      = i_key_valid & i_light_valid &
                     (i_key_pos == i_light_pos) & ~w_lock_eff;
        w_key_miss = i_key_valid & ~w_hit;
        // An expiring light that was never hit is a miss, unless it is hit
        // in the very cycle it expires.
        w_exp_miss = i_light_expired & ~r_hit_lock & ~w_hit;
        w_miss_cnt = {1'b0, w_key_miss} + {1'b0, w_exp_miss};

        w_score_play  = (w_hit && (r_score != '1)) ? r_score + SCORE_W'(1) : r_score;
        w_flicks_play = (i_light_new && (r_flicks != '1)) ? r_flicks + SCORE_W'(1) : r_flicks;

        w_time_play = r_time_left;
        if (w_mode_timed && i_tick_1hz && (r_time_left != 7'd0)) begin
            w_time_play = r_time_left - 7'd1;
        end

        w_lives_play = r_lives_left;
        if (w_mode_lives) begin
            if ({1'b0, w_miss_cnt} >= r_lives_left) begin
                w_lives_play = 3'd0;
            end else begin
                w_lives_play = r_lives_left - {1'b0, w_miss_cnt};
            end
        end

        // End-of-game test looks at the values after this cycle's updates.
        if (w_mode_timed) begin
            w_play_end = (w_time_play == 7'd0);
        end else if (w_mode_lives) begin
            w_play_end = (w_lives_play == 3'd0);
        end else begin
            w_play_end = (w_flicks_play == r_max_q) && !i_light_valid;
        end
    end

    // Next-state logic; play wins over every other event except in RESTART.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SETUP: begin
                if (i_play) w_state_next = ST_RESTART;
            end
            ST_WAIT: begin
                if (i_play) begin
                    w_state_next = ST_RESTART;
                end else if (i_tick_1hz && (r_ready_count == 4'd1)) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_play) begin
                    w_state_next = ST_RESTART;
                end else if (w_play_end) begin
                    w_state_next = ST_GAME_OVER;
                end
            end
            ST_GAME_OVER: begin
                if (i_play) w_state_next = ST_RESTART;
            end
            ST_RESTART: begin
                w_state_next = ST_WAIT;
            end
            default: begin
                w_state_next = ST_SETUP;
            end
        endcase
    end

    // Next values of configuration and counters; everything holds by default.
    always_comb begin
        w_mode_next     = r_mode_q;
        w_max_next      = r_max_q;
        w_score_next    = r_score;
        w_flicks_next   = r_flicks;
        w_ready_next    = r_ready_count;
        w_time_next     = r_time_left;
        w_lives_next    = r_lives_left;
        w_hit_lock_next = r_hit_lock;
        case (r_state)
            ST_RESTART: begin
                w_mode_next     = i_mode;
                w_max_next      = i_max_hits;
                w_score_next    = '0;
                w_flicks_next   = '0;
                w_ready_next    = 4'(READY_SECONDS);
                w_time_next     = 7'(GAME_SECONDS);
                w_lives_next    = 3'(LIVES);
                w_hit_lock_next = 1'b0;
            end
            ST_WAIT: begin
                if (!i_play && i_tick_1hz && (r_ready_count != 4'd0)) begin
                    w_ready_next = r_ready_count - 4'd1;
                end
            end
            ST_PLAY: begin
                if (!i_play) begin
                    w_score_next    = w_score_play;
                    w_flicks_next   = w_flicks_play;
                    w_time_next     = w_time_play;
                    w_lives_next    = w_lives_play;
                    w_hit_lock_next = w_hit | w_lock_eff;
                end
            end
            default: begin
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SETUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Configuration and game counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode_q      <= 2'd0;
            r_max_q       <= '0;
            r_score       <= '0;
            r_flicks      <= '0;
            r_ready_count <= 4'd0;
            r_time_left   <= 7'd0;
            r_lives_left  <= 3'd0;
            r_hit_lock    <= 1'b0;
        end else begin
            r_mode_q      <= w_mode_next;
            r_max_q       <= w_max_next;
            r_score       <= w_score_next;
            r_flicks      <= w_flicks_next;
            r_ready_count <= w_ready_next;
            r_time_left   <= w_time_next;
            r_lives_left  <= w_lives_next;
            r_hit_lock    <= w_hit_lock_next;
        end
    end

    // Outputs are registers or pure decodes of the registered state.
    assign o_state        = r_state;
    assign o_clear_n      = (r_state != ST_RESTART);
    assign o_countdown_en = (r_state == ST_WAIT);
    assign o_flick_en     = (r_state == ST_PLAY);
    assign o_game_over    = (r_state == ST_GAME_OVER);
    assign o_ready_count  = r_ready_count;
    assign o_time_left    = r_time_left;
    assign o_lives_left   = r_lives_left;
    assign o_score        = r_score;
    assign o_flicks       = r_flicks;

endmodule
